// File: rtl/regfile_rd.sv
// Register file: one write port, two registered read ports with write-through bypass.
// Entry 0 is hardwired to zero; synchronous active-high reset clears everything.
module regfile_rd #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  output logic          rd_valid
);

  localparam int NENT = 2 ** AW;

  logic [DW-1:0] mem [NENT];
  logic          wr_hit;
  logic [DW-1:0] ra_next;
  logic [DW-1:0] rb_next;

  assign wr_hit = we && (waddr != '0);

  // Bypass only for a real write; address 0 always reads as zero.
  always_comb begin
    ra_next = '0;
    rb_next = '0;
    if (ra_addr != '0) begin
      if (wr_hit && (waddr == ra_addr)) ra_next = wdata;
      else                              ra_next = mem[ra_addr];
    end
    if (rb_addr != '0) begin
      if (wr_hit && (waddr == rb_addr)) rb_next = wdata;
      else                              rb_next = mem[rb_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_data  <= '0;
      rb_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) begin
        ra_data <= ra_next;
        rb_data <= rb_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rd.sv
// Self-checking bench for regfile_rd: directed scenarios plus randomized traffic
// compared against a write-then-read array model.
module tb_regfile_rd;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NENT = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst, we, re;
  logic [AW-1:0] waddr, ra_addr, rb_addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] ra_data, rb_data;
  logic          rd_valid;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [NENT];
  logic [DW-1:0] m_a, m_b;
  logic          m_v;

  regfile_rd #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: reset clears; otherwise the write lands first and reads see the
  // updated array, which is what write-through bypass means.
  task automatic model_edge(input logic r, input logic w, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic rd,
                            input logic [AW-1:0] a, input logic [AW-1:0] b);
    if (r) begin
      for (int i = 0; i < NENT; i++) mdl[i] = '0;
      m_a = '0; m_b = '0; m_v = 1'b0;
    end else begin
      if (w && wa != 0) mdl[wa] = wd;
      m_v = rd;
      if (rd) begin
        m_a = (a == 0) ? '0 : mdl[a];
        m_b = (b == 0) ? '0 : mdl[b];
      end
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic rd,
                     input logic [AW-1:0] a, input logic [AW-1:0] b);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd; re = rd; ra_addr = a; rb_addr = b;
    @(posedge clk);
    model_edge(r, w, wa, wd, rd, a, b);
    #1;
    chk("ra_data", ra_data, m_a);
    chk("rb_data", rb_data, m_b);
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_v});
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; waddr = '0; wdata = '0; ra_addr = '0; rb_addr = '0;
    for (int i = 0; i < NENT; i++) mdl[i] = '0;
    m_a = '0; m_b = '0; m_v = 1'b0;

    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_ra", ra_data, 32'h0);

    // Read after reset returns zeros, valid one cycle later.
    cyc(0, 0, 0, 0, 1, 3, 31);
    chk("rst_read_valid", {31'b0, rd_valid}, 32'h1);
    chk("rst_read_rb", rb_data, 32'h0);

    // Write then read same entry on both ports.
    cyc(0, 1, 7, 32'hDEADBEEF, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 7, 7);
    chk("wr_rd_a", ra_data, 32'hDEADBEEF);
    chk("wr_rd_b", rb_data, 32'hDEADBEEF);

    // Bypass on port A, stored data on port B.
    cyc(0, 1, 8, 32'hA5A5A5A5, 0, 0, 0);
    cyc(0, 1, 9, 32'h12345678, 1, 9, 8);
    chk("bypass_a", ra_data, 32'h12345678);
    chk("nobypass_b", rb_data, 32'hA5A5A5A5);

    // Same-address bypass on both ports.
    cyc(0, 1, 10, 32'hCAFEF00D, 1, 10, 10);
    chk("bypass_both", rb_data, 32'hCAFEF00D);

    // Address 0 ignores writes and bypass.
    cyc(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
    chk("zero_bypass", ra_data, 32'h0);
    cyc(0, 0, 0, 0, 1, 0, 7);
    chk("zero_reread", ra_data, 32'h0);

    // Hold while re=0, writes continue.
    cyc(0, 1, 5, 32'h55, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 5, 5);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 5, 32'h66, 0, 7, 9);
      chk("hold_a", ra_data, 32'h55);
      chk("hold_valid", {31'b0, rd_valid}, 32'h0);
    end
    cyc(0, 0, 0, 0, 1, 5, 0);
    chk("after_hold", ra_data, 32'h66);

    // Reset wins over simultaneous write and read.
    cyc(1, 1, 4, 32'h44, 1, 4, 4);
    chk("rst_prio_valid", {31'b0, rd_valid}, 32'h0);
    cyc(0, 0, 0, 0, 1, 4, 5);
    chk("rst_drop_wr", ra_data, 32'h0);
    chk("rst_clr_5", rb_data, 32'h0);

    // Randomized traffic, narrow address range half the time to force collisions.
    for (int n = 0; n < 3000; n++) begin
      logic          r, w, rd;
      logic [AW-1:0] wa, a, b;
      logic [DW-1:0] wd;
      bit            narrow;
      narrow = $urandom_range(0, 1) == 1;
      r  = ($urandom_range(0, 99) == 0);
      w  = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 3) != 0);
      wa = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      a  = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      b  = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wd = $urandom;
      cyc(r, w, wa, wd, rd, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_rd.md
REGFILE_RD -- requirements
Module: regfile_rd

Interface
REQ-001 Parameter DW, default 32, data width of each register entry.
REQ-002 Parameter AW, default 5, address width; entry count is 2**AW.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 we  input  1  write enable for the single write port.
REQ-006 waddr  input  AW  write address.
REQ-007 wdata  input  DW  write data.
REQ-008 re  input  1  read enable; one read request per cycle, both read ports together.
REQ-009 ra_addr  input  AW  read port A address.
REQ-010 rb_addr  input  AW  read port B address.
REQ-011 ra_data  output  DW  registered read data, port A.
REQ-012 rb_data  output  DW  registered read data, port B.
REQ-013 rd_valid  output  1  high for one cycle when ra_data/rb_data carry a new result.

Function
REQ-014 The storage array SHALL hold 2**AW entries of DW bits.
REQ-015 Entry 0 SHALL always read as 0; writes to address 0 SHALL be discarded.
REQ-016 On a rising edge with we=1, rst=0, waddr!=0, entry[waddr] SHALL take wdata.
REQ-017 On a rising edge with re=1, rst=0, ra_data/rb_data SHALL load the entries at ra_addr/rb_addr; read latency is exactly 1 cycle.
REQ-018 Write-through bypass: if re=1 and we=1 in the same cycle and ra_addr==waddr!=0, ra_data SHALL load wdata, not the old entry; same rule for port B, independently.
REQ-019 Bypass SHALL NOT apply when waddr==0; such a read SHALL return 0.
REQ-020 Both ports addressing the same entry SHALL return identical data, including under bypass.
REQ-021 With re=0, ra_data and rb_data SHALL hold their previous values; writes still proceed.
REQ-022 rd_valid SHALL equal re registered (re sampled at edge N -> rd_valid high during cycle N+1), forced 0 by reset.
REQ-023 Back-to-back reads SHALL be supported every cycle with no bubbles; a write at edge N SHALL be visible to a non-bypassed read at edge N+1 or later.
REQ-024 No combinational path SHALL exist from any input to any output.

Reset
REQ-025 On a rising edge with rst=1, every entry SHALL clear to 0, and ra_data, rb_data and rd_valid SHALL clear to 0.
REQ-026 rst SHALL take priority over we and re in the same cycle; the write and read requested in that cycle SHALL be dropped.
REQ-027 Assertion of rst between edges SHALL have no effect until the next rising edge.
REQ-028 On the first edge after rst deasserts, normal write/read behaviour SHALL resume with no further idle cycles.

Verification
REQ-029 Reset, then re=1, ra_addr=3, rb_addr=31 -> next cycle ra_data=0, rb_data=0, rd_valid=1.
REQ-030 Write 0xDEADBEEF to addr 7; next cycle re=1, ra_addr=7, rb_addr=7 -> both outputs 0xDEADBEEF one cycle later.
REQ-031 Same cycle: we=1, waddr=9, wdata=0x12345678, re=1, ra_addr=9, rb_addr=8 (holding 0xA5A5A5A5) -> ra_data=0x12345678, rb_data=0xA5A5A5A5.
REQ-032 Write 0xFFFFFFFF to addr 0 with re=1, ra_addr=0 in the same cycle, then read addr 0 again -> ra_data=0 both times.
REQ-033 Load addr 5=0x55; set re=0 for 3 cycles while writing addr 5=0x66 -> ra_data holds the last read value, rd_valid=0; re=1 -> 0x66.
REQ-034 rst=1 in the same cycle as we=1 to addr 4=0x44 and re=1 -> outputs 0, rd_valid=0; subsequent read of addr 4 -> 0.
